// File: rtl/dispense_pkg.sv
// -----------------------------------------------------------------------------
// dispense_pkg
// Shared types and constants for the dispense scheduler slice.
//   state_e        : scheduler FSM states (ST_IDLE, ST_PULSE, ST_GAP)
//   SLOT_*         : bit position of each daily slot inside a compartment's
//                    3-bit mask field {evening, afternoon, morning}
//   SLOTS_PER_COMP : width of one compartment's mask field
//   max2()         : elaboration-time helper for derived widths
// -----------------------------------------------------------------------------
package dispense_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    localparam int SLOT_MORNING   = 0;
    localparam int SLOT_AFTERNOON = 1;
    localparam int SLOT_EVENING   = 2;
    localparam int SLOTS_PER_COMP = 3;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dispense_scheduler_if.sv
// -----------------------------------------------------------------------------
// dispense_scheduler_if
// Bundles the scheduler's upstream request inputs and downstream actuator
// outputs.
//   morningP/afternoonP/eveningP : single-cycle slot strobes
//   mask      [3*NUM_COMP]       : per-compartment slot enables
//   override  [NUM_COMP]         : manual press levels (rising edge = request)
//   secondP                      : one-cycle strobe per second
//   motor     [NUM_COMP]         : one-hot actuator drive
//   busy, done, done_id, pending, alarm : status outputs
//   dbg_state                    : scheduler FSM state, for observation
// Modports: master = upstream/downstream environment, slave = scheduler.
//
// Signalling: there is no valid/ready pair on this bus. Slot pulses and secondP
// are single-cycle strobes sampled on the rising clock edge, override is a
// level whose rising edge counts once, and done is a one-cycle strobe that
// qualifies done_id in the same cycle; no input is ever back-pressured.
// -----------------------------------------------------------------------------
interface dispense_scheduler_if #(
    parameter int NUM_COMP = 2,
    parameter int IDW      = 1
);
    import dispense_pkg::*;

    logic                    morningP;
    logic                    afternoonP;
    logic                    eveningP;
    logic [3*NUM_COMP-1:0]   mask;
    logic [NUM_COMP-1:0]     override;
    logic                    secondP;

    logic [NUM_COMP-1:0]     motor;
    logic                    busy;
    logic                    done;
    logic [IDW-1:0]          done_id;
    logic [NUM_COMP-1:0]     pending;
    logic                    alarm;
    state_e                  dbg_state;

    modport master (
        output morningP, afternoonP, eveningP, mask, override, secondP,
        input  motor, busy, done, done_id, pending, alarm, dbg_state
    );

    modport slave (
        input  morningP, afternoonP, eveningP, mask, override, secondP,
        output motor, busy, done, done_id, pending, alarm, dbg_state
    );

endinterface

// File: rtl/dispense_rr_arb.sv
// -----------------------------------------------------------------------------
// dispense_rr_arb
// Combinational round-robin pick: first set bit of i_pending searching upward
// from i_last+1, wrapping to bit 0. The pointer itself lives in the scheduler.
//   i_pending [NUM_COMP] : latched requests
//   i_last    [IDW]      : most recently granted compartment
//   o_grant   [IDW]      : selected compartment (0 when none)
//   o_valid              : at least one request pending
// -----------------------------------------------------------------------------
module dispense_rr_arb #(
    parameter int NUM_COMP = 2,
    parameter int IDW      = 1
) (
    input  logic [NUM_COMP-1:0] i_pending,
    input  logic [IDW-1:0]      i_last,
    output logic [IDW-1:0]      o_grant,
    output logic                o_valid
);

    // Two passes instead of a rotate: first the indices above i_last, then
    // (wrap) everything from 0. Descending loops leave the lowest hit in place.
    always_comb begin
        o_grant = '0;
        o_valid = 1'b0;
        for (int c = NUM_COMP - 1; c >= 0; c--) begin
            if (i_pending[c] && (IDW'(c) > i_last)) begin
                o_valid = 1'b1;
                o_grant = IDW'(c);
            end
        end
        if (!o_valid) begin
            for (int c = NUM_COMP - 1; c >= 0; c--) begin
                if (i_pending[c]) begin
                    o_valid = 1'b1;
                    o_grant = IDW'(c);
                end
            end
        end
    end

endmodule

// File: rtl/dispense_scheduler.sv
// -----------------------------------------------------------------------------
// dispense_scheduler
// Latches per-compartment dispense requests (masked slot pulses and override
// rising edges) and serialises them onto one actuator driver: round-robin
// grant, fixed PULSE_CYCLES motor pulse, then GAP_CYCLES of forced idle.
//   clock  : system clock, rising edge
//   resetn : asynchronous active-low reset
//   bus    : dispense_scheduler_if.slave (request inputs, motor/status outputs)
// Optional feature macro DISPENSE_ALARM_EN: when defined, done raises alarm,
// which is held for ALARM_SECS secondP strobes; otherwise alarm is tied low.
// -----------------------------------------------------------------------------
module dispense_scheduler
    import dispense_pkg::*;
#(
    parameter int NUM_COMP     = 2,
    parameter int PULSE_CYCLES = 10000000,
    parameter int GAP_CYCLES   = 1000,
    parameter int ALARM_SECS   = 5
) (
    input  logic              clock,
    input  logic              resetn,
    dispense_scheduler_if.slave bus
);

    localparam int IDW     = (NUM_COMP > 1) ? $clog2(NUM_COMP) : 1;
    localparam int CNT_MAX = max2(PULSE_CYCLES, GAP_CYCLES);
    localparam int CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0]  PULSE_LOAD = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0]  GAP_LOAD   = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [IDW-1:0] LAST_RST   = IDW'(NUM_COMP - 1);

    state_e                r_state,   w_state_nxt;
    logic [CW-1:0]         r_cnt,     w_cnt_nxt;
    logic [IDW-1:0]        r_last,    w_last_nxt;
    logic [NUM_COMP-1:0]   r_motor,   w_motor_nxt;
    logic                  r_done,    w_done_nxt;
    logic [IDW-1:0]        r_done_id, w_done_id_nxt;
    logic [NUM_COMP-1:0]   r_pending, w_pending_nxt;
    logic [NUM_COMP-1:0]   r_ovr_prev;

    logic [NUM_COMP-1:0]   w_req;
    logic [NUM_COMP-1:0]   w_block;
    logic [NUM_COMP-1:0]   w_clear;
    logic [NUM_COMP-1:0]   w_cur_oh;
    logic [NUM_COMP-1:0]   w_arb_oh;
    logic [IDW-1:0]        w_arb_id;
    logic                  w_arb_valid;

    // r_last doubles as the id of the compartment currently being served.
    dispense_rr_arb #(
        .NUM_COMP (NUM_COMP),
        .IDW      (IDW)
    ) u_arb (
        .i_pending (r_pending),
        .i_last    (r_last),
        .o_grant   (w_arb_id),
        .o_valid   (w_arb_valid)
    );

    always_comb begin
        w_req    = '0;
        w_cur_oh = '0;
        w_arb_oh = '0;
        for (int c = 0; c < NUM_COMP; c++) begin
            w_req[c] = (bus.morningP   & bus.mask[SLOTS_PER_COMP*c + SLOT_MORNING])
                     | (bus.afternoonP & bus.mask[SLOTS_PER_COMP*c + SLOT_AFTERNOON])
                     | (bus.eveningP   & bus.mask[SLOTS_PER_COMP*c + SLOT_EVENING])
                     | (bus.override[c] & ~r_ovr_prev[c]);
            w_cur_oh[c] = (r_last   == IDW'(c));
            w_arb_oh[c] = (w_arb_id == IDW'(c));
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_last_nxt    = r_last;
        w_motor_nxt   = r_motor;
        w_done_nxt    = 1'b0;
        w_done_id_nxt = r_done_id;
        w_block       = '0;
        w_clear       = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_arb_valid) begin
                    // Clearing wins over a same-cycle request: that request is merged.
                    w_clear     = w_arb_oh;
                    w_last_nxt  = w_arb_id;
                    w_cnt_nxt   = PULSE_LOAD;
                    w_motor_nxt = w_arb_oh;
                    w_state_nxt = ST_PULSE;
                end
            end
            ST_PULSE: begin
                // Requests for the compartment already dispensing are merged.
                w_block = w_cur_oh;
                if (r_cnt == '0) begin
                    w_motor_nxt   = '0;
                    w_done_nxt    = 1'b1;
                    w_done_id_nxt = r_last;
                    if (GAP_CYCLES == 0) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_GAP;
                        w_cnt_nxt   = GAP_LOAD;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_GAP: begin
                w_motor_nxt = '0;
                if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_motor_nxt = '0;
            end
        endcase
        w_pending_nxt = (r_pending | (w_req & ~w_block)) & ~w_clear;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_last     <= LAST_RST;
            r_motor    <= '0;
            r_done     <= 1'b0;
            r_done_id  <= '0;
            r_pending  <= '0;
            r_ovr_prev <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_last     <= w_last_nxt;
            r_motor    <= w_motor_nxt;
            r_done     <= w_done_nxt;
            r_done_id  <= w_done_id_nxt;
            r_pending  <= w_pending_nxt;
            r_ovr_prev <= bus.override;
        end
    end

`ifdef DISPENSE_ALARM_EN
    localparam int SW = (ALARM_SECS < 2) ? 1 : $clog2(ALARM_SECS + 1);

    logic          r_alarm;
    logic [SW-1:0] r_sec_cnt;

    // done has priority over a coincident secondP and restarts the hold.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_alarm   <= 1'b0;
            r_sec_cnt <= '0;
        end else if (r_done) begin
            r_alarm   <= 1'b1;
            r_sec_cnt <= '0;
        end else if (r_alarm && bus.secondP) begin
            if (r_sec_cnt == SW'(ALARM_SECS - 1)) begin
                r_alarm   <= 1'b0;
                r_sec_cnt <= '0;
            end else begin
                r_sec_cnt <= r_sec_cnt + 1'b1;
            end
        end
    end

    assign bus.alarm = r_alarm;
`else
    logic w_unused_second;
    assign w_unused_second = bus.secondP;
    assign bus.alarm       = 1'b0;
`endif

    assign bus.motor     = r_motor;
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.done      = r_done;
    assign bus.done_id   = r_done_id;
    assign bus.pending   = r_pending;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_dispense_scheduler.sv
// -----------------------------------------------------------------------------
// tb_dispense_scheduler
// Directed scenarios plus a randomized run against a timestamp-based reference
// model of the scheduler (NUM_COMP=2, PULSE_CYCLES=4, GAP_CYCLES=2).
// Alarm expectations follow the DISPENSE_ALARM_EN build setting.
// -----------------------------------------------------------------------------
module tb_dispense_scheduler;
    import dispense_pkg::*;

    localparam int NC = 2;
    localparam int P  = 4;
    localparam int G  = 2;
    localparam int AS = 5;
    localparam logic [NC-1:0] ONE = 1;

    logic clock;
    logic resetn;

    int checks   = 0;
    int failures = 0;

    dispense_scheduler_if #(.NUM_COMP(NC), .IDW(1)) bus ();

    dispense_scheduler #(
        .NUM_COMP     (NC),
        .PULSE_CYCLES (P),
        .GAP_CYCLES   (G),
        .ALARM_SECS   (AS)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    // A dispense granted at edge t drives the motor after edges t..t+P-1,
    // reports done after edge t+P, keeps busy through t+P+G-1, and the next
    // grant may happen no earlier than edge t+P+G+1.
    int            now_k;
    logic [NC-1:0] m_pend;
    logic [NC-1:0] m_ovr_prev;
    int            m_last;
    int            m_gid;
    int            m_gt;
    int            m_next_ok;
    int            m_sec;
    logic [NC-1:0] exp_motor;
    logic [NC-1:0] exp_pending;
    logic          exp_done;
    logic          exp_busy;
    logic          exp_alarm;
    int            exp_done_id;

    task automatic model_reset();
        now_k       = 0;
        m_pend      = '0;
        m_ovr_prev  = '0;
        m_last      = NC - 1;
        m_gid       = -1;
        m_gt        = 0;
        m_next_ok   = 0;
        m_sec       = 0;
        exp_motor   = '0;
        exp_pending = '0;
        exp_done    = 1'b0;
        exp_busy    = 1'b0;
        exp_alarm   = 1'b0;
        exp_done_id = 0;
    endtask

    task automatic model_edge();
        logic [NC-1:0] rise;
        logic [NC-1:0] req;
        logic [NC-1:0] blk;
        logic          prev_done;
        int            pick;
        rise       = bus.override & ~m_ovr_prev;
        m_ovr_prev = bus.override;
        req        = '0;
        for (int c = 0; c < NC; c++) begin
            req[c] = (bus.morningP   && bus.mask[3*c])
                  || (bus.afternoonP && bus.mask[3*c+1])
                  || (bus.eveningP   && bus.mask[3*c+2])
                  || rise[c];
        end
        blk = '0;
        if (m_gid >= 0 && now_k >= m_gt && now_k <= m_gt + P) blk = ONE << m_gid;
        if (now_k >= m_next_ok && m_pend != '0) begin
            pick = -1;
            for (int s = 1; s <= NC; s++) begin
                int c2;
                c2 = (m_last + s) % NC;
                if (pick < 0 && ((m_pend >> c2) & ONE) != '0) pick = c2;
            end
            m_gid     = pick;
            m_gt      = now_k;
            m_next_ok = now_k + P + G + 1;
            m_last    = pick;
            m_pend    = m_pend & ~(ONE << pick);
            blk       = ONE << pick;
        end
        m_pend      = m_pend | (req & ~blk);
        prev_done   = exp_done;
        exp_motor   = (m_gid >= 0 && now_k >= m_gt && now_k <= m_gt + P - 1) ? (ONE << m_gid) : '0;
        exp_done    = (m_gid >= 0 && now_k == m_gt + P);
        exp_done_id = (m_gid >= 0) ? m_gid : 0;
        exp_busy    = (m_gid >= 0 && now_k <= m_gt + P + G - 1);
        exp_pending = m_pend;
`ifdef DISPENSE_ALARM_EN
        if (prev_done) begin
            exp_alarm = 1'b1;
            m_sec     = 0;
        end else if (exp_alarm && bus.secondP) begin
            m_sec++;
            if (m_sec == AS) begin
                exp_alarm = 1'b0;
                m_sec     = 0;
            end
        end
`else
        exp_alarm = 1'b0;
`endif
        now_k++;
    endtask

    // ---------------- driver tasks ----------------
    // Called at a falling edge with inputs already set; returns at the next
    // falling edge with strobes cleared, outputs ready to sample.
    task automatic step();
        model_edge();
        @(posedge clock);
        @(negedge clock);
        bus.morningP   = 1'b0;
        bus.afternoonP = 1'b0;
        bus.eveningP   = 1'b0;
        bus.secondP    = 1'b0;
    endtask

    task automatic do_reset();
        bus.morningP   = 1'b0;
        bus.afternoonP = 1'b0;
        bus.eveningP   = 1'b0;
        bus.secondP    = 1'b0;
        bus.override   = '0;
        bus.mask       = '0;
        resetn         = 1'b0;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        model_reset();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        checks++; if (bus.motor !== 2'b00) begin failures++; $display("FAIL reset_motor got=%b want=00", bus.motor); end
        checks++; if (bus.pending !== 2'b00) begin failures++; $display("FAIL reset_pending got=%b want=00", bus.pending); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", bus.done); end
        checks++; if (bus.done_id !== 1'b0) begin failures++; $display("FAIL reset_done_id got=%b want=0", bus.done_id); end
        checks++; if (bus.alarm !== 1'b0) begin failures++; $display("FAIL reset_alarm got=%b want=0", bus.alarm); end
        checks++; if (bus.dbg_state !== ST_IDLE) begin failures++; $display("FAIL reset_state got=%0d want=%0d", bus.dbg_state, ST_IDLE); end
    endtask

    task automatic test_single();
        logic [1:0] want_m;
        do_reset();
        bus.mask     = 6'b000_001;
        bus.morningP = 1'b1;
        step();
        checks++; if (bus.pending !== 2'b01) begin failures++; $display("FAIL single_pend_latch got=%b want=01", bus.pending); end
        checks++; if (bus.motor !== 2'b00) begin failures++; $display("FAIL single_motor_j0 got=%b want=00", bus.motor); end
        for (int j = 1; j <= 7; j++) begin
            step();
            want_m = (j >= 1 && j <= 4) ? 2'b01 : 2'b00;
            checks++; if (bus.motor !== want_m) begin failures++; $display("FAIL single_motor j=%0d got=%b want=%b", j, bus.motor, want_m); end
            checks++; if (bus.done !== (j == 5)) begin failures++; $display("FAIL single_done j=%0d got=%b want=%b", j, bus.done, (j == 5)); end
            checks++; if (bus.busy !== (j <= 6)) begin failures++; $display("FAIL single_busy j=%0d got=%b want=%b", j, bus.busy, (j <= 6)); end
            checks++; if (bus.pending !== 2'b00) begin failures++; $display("FAIL single_pend j=%0d got=%b want=00", j, bus.pending); end
            if (j == 5) begin
                checks++; if (bus.done_id !== 1'b0) begin failures++; $display("FAIL single_done_id got=%b want=0", bus.done_id); end
            end
        end
    endtask

    task automatic test_two_comp();
        logic [1:0] want_m;
        do_reset();
        bus.mask     = 6'b001_001;
        bus.morningP = 1'b1;
        step();
        checks++; if (bus.pending !== 2'b11) begin failures++; $display("FAIL two_pend got=%b want=11", bus.pending); end
        for (int j = 1; j <= 12; j++) begin
            step();
            want_m = (j >= 1 && j <= 4) ? 2'b01 : (j >= 8 && j <= 11) ? 2'b10 : 2'b00;
            checks++; if (bus.motor !== want_m) begin failures++; $display("FAIL two_motor j=%0d got=%b want=%b", j, bus.motor, want_m); end
            checks++; if (bus.motor === 2'b11) begin failures++; $display("FAIL two_onehot j=%0d got=%b want=not_11", j, bus.motor); end
            checks++; if (bus.done !== (j == 5 || j == 12)) begin failures++; $display("FAIL two_done j=%0d got=%b want=%b", j, bus.done, (j == 5 || j == 12)); end
            if (j == 12) begin
                checks++; if (bus.done_id !== 1'b1) begin failures++; $display("FAIL two_done_id got=%b want=1", bus.done_id); end
            end
        end
    endtask

    task automatic test_override();
        int n_done;
        do_reset();
        n_done       = 0;
        bus.override = 2'b10;
        for (int j = 0; j < 20; j++) begin
            step();
            if (bus.done === 1'b1) begin
                n_done++;
                checks++; if (bus.done_id !== 1'b1) begin failures++; $display("FAIL ovr_done_id got=%b want=1", bus.done_id); end
            end
            checks++; if (bus.motor[0] !== 1'b0) begin failures++; $display("FAIL ovr_motor0 j=%0d got=%b want=0", j, bus.motor[0]); end
        end
        checks++; if (n_done != 1) begin failures++; $display("FAIL ovr_held_count got=%0d want=1", n_done); end
        // Release and press again, then re-press while that pulse is running.
        n_done       = 0;
        bus.override = 2'b00; step();
        bus.override = 2'b10; step();
        step();
        checks++; if (bus.motor !== 2'b10) begin failures++; $display("FAIL ovr_repress_motor got=%b want=10", bus.motor); end
        bus.override = 2'b00; step();
        bus.override = 2'b10; step();
        for (int j = 0; j < 20; j++) begin
            step();
            if (bus.done === 1'b1) n_done++;
        end
        checks++; if (n_done != 1) begin failures++; $display("FAIL ovr_merge_count got=%0d want=1", n_done); end
        checks++; if (bus.pending !== 2'b00) begin failures++; $display("FAIL ovr_pend_end got=%b want=00", bus.pending); end
    endtask

    task automatic test_back_to_back();
        logic [0:0] exp_q[$];
        do_reset();
        exp_q = '{1'b0, 1'b1, 1'b0, 1'b1};
        bus.mask = 6'b001_001;
        for (int j = 0; j < 40; j++) begin
            bus.morningP = (j % 3 == 0);
            step();
            if (bus.done === 1'b1 && exp_q.size() > 0) begin
                logic [0:0] want;
                want = exp_q.pop_front();
                checks++; if (bus.done_id !== want) begin failures++; $display("FAIL b2b_order got=%b want=%b", bus.done_id, want); end
            end
            checks++; if (bus.motor === 2'b11) begin failures++; $display("FAIL b2b_onehot j=%0d got=%b want=not_11", j, bus.motor); end
        end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_missing got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_reset_mid_pulse();
        do_reset();
        bus.mask     = 6'b001_001;
        bus.morningP = 1'b1;
        step();
        step();
        step();
        checks++; if (bus.motor !== 2'b01) begin failures++; $display("FAIL rst_pre_motor got=%b want=01", bus.motor); end
        resetn = 1'b0;
        #1;
        checks++; if (bus.motor !== 2'b00) begin failures++; $display("FAIL rst_async_motor got=%b want=00", bus.motor); end
        checks++; if (bus.pending !== 2'b00) begin failures++; $display("FAIL rst_async_pend got=%b want=00", bus.pending); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_async_busy got=%b want=0", bus.busy); end
        @(negedge clock);
        bus.mask = '0;
        resetn   = 1'b1;
        model_reset();
        for (int j = 0; j < 10; j++) begin
            step();
            checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL rst_after_done j=%0d got=%b want=0", j, bus.done); end
            checks++; if (bus.busy !== 1'b0 || bus.pending !== 2'b00 || bus.motor !== 2'b00) begin
                failures++; $display("FAIL rst_after_idle j=%0d got=%b/%b/%b want=0/00/00", j, bus.busy, bus.pending, bus.motor);
            end
        end
    endtask

`ifdef DISPENSE_ALARM_EN
    task automatic test_alarm();
        do_reset();
        bus.mask     = 6'b000_001;
        bus.morningP = 1'b1;
        for (int j = 0; j <= 5; j++) step();
        checks++; if (bus.alarm !== 1'b0) begin failures++; $display("FAIL alarm_done_cycle got=%b want=0", bus.alarm); end
        step();
        checks++; if (bus.alarm !== 1'b1) begin failures++; $display("FAIL alarm_set got=%b want=1", bus.alarm); end
        for (int n = 1; n <= AS; n++) begin
            bus.secondP = 1'b1;
            step();
            checks++; if (bus.alarm !== (n < AS)) begin failures++; $display("FAIL alarm_hold n=%0d got=%b want=%b", n, bus.alarm, (n < AS)); end
        end
        // Restart: a second done after three seconds begins a fresh hold.
        bus.morningP = 1'b1;
        for (int j = 0; j <= 6; j++) step();
        for (int n = 1; n <= 3; n++) begin bus.secondP = 1'b1; step(); end
        bus.morningP = 1'b1;
        for (int j = 0; j <= 6; j++) step();
        checks++; if (bus.alarm !== 1'b1) begin failures++; $display("FAIL alarm_reset_set got=%b want=1", bus.alarm); end
        for (int n = 1; n <= AS; n++) begin
            bus.secondP = 1'b1;
            step();
            checks++; if (bus.alarm !== (n < AS)) begin failures++; $display("FAIL alarm_restart n=%0d got=%b want=%b", n, bus.alarm, (n < AS)); end
        end
    endtask
`else
    task automatic test_alarm();
        do_reset();
        bus.mask     = 6'b000_001;
        bus.morningP = 1'b1;
        for (int j = 0; j < 14; j++) begin
            bus.secondP = (j % 2 == 0);
            step();
            checks++; if (bus.alarm !== 1'b0) begin failures++; $display("FAIL alarm_off j=%0d got=%b want=0", j, bus.alarm); end
        end
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if (n % 64 == 0) bus.mask = 6'($urandom_range(0, 63));
            bus.morningP   = ($urandom_range(0, 11) == 0);
            bus.afternoonP = ($urandom_range(0, 11) == 0);
            bus.eveningP   = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 5) == 0) bus.override[0] = ~bus.override[0];
            if ($urandom_range(0, 5) == 0) bus.override[1] = ~bus.override[1];
            bus.secondP = ($urandom_range(0, 2) == 0);
            step();
            checks++; if (bus.motor !== exp_motor) begin failures++; $display("FAIL rnd_motor n=%0d got=%b want=%b", n, bus.motor, exp_motor); end
            checks++; if (bus.pending !== exp_pending) begin failures++; $display("FAIL rnd_pending n=%0d got=%b want=%b", n, bus.pending, exp_pending); end
            checks++; if (bus.busy !== exp_busy) begin failures++; $display("FAIL rnd_busy n=%0d got=%b want=%b", n, bus.busy, exp_busy); end
            checks++; if (bus.done !== exp_done) begin failures++; $display("FAIL rnd_done n=%0d got=%b want=%b", n, bus.done, exp_done); end
            checks++; if (bus.alarm !== exp_alarm) begin failures++; $display("FAIL rnd_alarm n=%0d got=%b want=%b", n, bus.alarm, exp_alarm); end
            if (exp_done) begin
                checks++; if (int'(bus.done_id) != exp_done_id) begin failures++; $display("FAIL rnd_done_id n=%0d got=%0d want=%0d", n, bus.done_id, exp_done_id); end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        resetn         = 1'b0;
        bus.morningP   = 1'b0;
        bus.afternoonP = 1'b0;
        bus.eveningP   = 1'b0;
        bus.secondP    = 1'b0;
        bus.override   = '0;
        bus.mask       = '0;
        model_reset();
        @(negedge clock);
        test_reset();
        test_single();
        test_two_comp();
        test_override();
        test_back_to_back();
        test_reset_mid_pulse();
        test_alarm();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
